// File: rtl/rule110_seed_loader.sv
// rule110_seed_loader
// Builds a WIDTH-bit initial generation for the Rule 110 core from byte-wide
// switch input and offers it to the core over a valid/ready handshake.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   synchronous active-low reset
//   ena          in   design enable (synchronizers run regardless)
//   byte_in      in   [7:0] switch byte, asynchronous, quasi-static
//   byte_strobe  in   asynchronous, rising edge commits byte_in
//   frame_start  in   asynchronous, rising edge starts a new seed
//   seed_out     out  [WIDTH-1:0] assembled seed, first byte in the MSBs
//   seed_valid   out  seed complete and held
//   seed_ready   in   consumer accepts the seed
//   load_count   out  [CW-1:0] bytes captured in the current frame
//   busy         out  high while collecting bytes
//   overflow     out  sticky, a strobe arrived while a seed was held
module rule110_seed_loader #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned CW    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [7:0]       byte_in,
   input  logic             byte_strobe,
   input  logic             frame_start,
   output logic [WIDTH-1:0] seed_out,
   output logic             seed_valid,
   input  logic             seed_ready,
   output logic [CW-1:0]    load_count,
   output logic             busy,
   output logic             overflow
);

   localparam int unsigned BYTES = WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // Two synchronizer stages plus a history stage per async control pin.
   logic       strb_s1_q, strb_s2_q, strb_s3_q;
   logic       start_s1_q, start_s2_q, start_s3_q;
   // Byte data travels with the same depth as the strobe so it is aligned
   // with the strobe pulse.
   logic [7:0] byte_s1_q, byte_s2_q;

   logic       strb_pulse;
   logic       start_pulse;

   state_t           state_q;
   logic [WIDTH-1:0] seed_q;
   logic             valid_q;
   logic [CW-1:0]    count_q;
   logic             busy_q;
   logic             ovf_q;

   // Synchronizers keep running while ena is low so that raising ena
   // never reveals a stale edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         strb_s1_q  <= 1'b0;
         strb_s2_q  <= 1'b0;
         strb_s3_q  <= 1'b0;
         start_s1_q <= 1'b0;
         start_s2_q <= 1'b0;
         start_s3_q <= 1'b0;
         byte_s1_q  <= '0;
         byte_s2_q  <= '0;
      end else begin
         strb_s1_q  <= byte_strobe;
         strb_s2_q  <= strb_s1_q;
         strb_s3_q  <= strb_s2_q;
         start_s1_q <= frame_start;
         start_s2_q <= start_s1_q;
         start_s3_q <= start_s2_q;
         byte_s1_q  <= byte_in;
         byte_s2_q  <= byte_s1_q;
      end
   end

   assign strb_pulse  = strb_s2_q & ~strb_s3_q;
   assign start_pulse = start_s2_q & ~start_s3_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         seed_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (ena) begin
         if (start_pulse) begin
            // A start pulse wins over a same-cycle strobe in every state.
            // In HOLD a same-cycle handshake would also land in COLLECT with
            // count cleared, so applying the start alone is equivalent.
            state_q <= COLLECT;
            seed_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b1;
            ovf_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  // Strobes are ignored until a frame is started.
               end
               COLLECT: begin
                  if (strb_pulse) begin
                     seed_q  <= {seed_q[WIDTH-9:0], byte_s2_q};
                     count_q <= count_q + CW'(1);
                     if (count_q == CW'(BYTES - 1)) begin
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               HOLD: begin
                  if (strb_pulse) begin
                     ovf_q <= 1'b1;
                  end
                  if (valid_q && seed_ready) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     count_q <= '0;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign seed_out   = seed_q;
   assign seed_valid = valid_q;
   assign load_count = count_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_rule110_seed_loader.sv
// tb_rule110_seed_loader
// Directed, table-driven bench for rule110_seed_loader with default
// parameters (256-bit seed, 32 bytes, 6-bit load_count).
module tb_rule110_seed_loader;

   localparam int unsigned WIDTH = 256;
   localparam int unsigned CW    = 6;

   localparam int OP_START  = 0;
   localparam int OP_STROBE = 1;
   localparam int OP_HS     = 2;

   logic             clk;
   logic             rst_n;
   logic             ena;
   logic [7:0]       byte_in;
   logic             byte_strobe;
   logic             frame_start;
   logic [WIDTH-1:0] seed_out;
   logic             seed_valid;
   logic             seed_ready;
   logic [CW-1:0]    load_count;
   logic             busy;
   logic             overflow;

   int n_cmp;
   int n_bad;

   typedef struct {
      int               op;
      logic [7:0]       data;
      logic [CW-1:0]    cnt;
      logic             valid;
      logic             busy;
      logic             ovf;
      logic [WIDTH-1:0] seed;
   } vec_t;

   vec_t tbl[$];

   rule110_seed_loader #(
      .WIDTH(WIDTH),
      .CW   (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .byte_in    (byte_in),
      .byte_strobe(byte_strobe),
      .frame_start(frame_start),
      .seed_out   (seed_out),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready),
      .load_count (load_count),
      .busy       (busy),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [WIDTH-1:0] act,
                      input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [CW-1:0] cnt,
                          input logic v, input logic b, input logic o,
                          input logic [WIDTH-1:0] s);
      chk({tag, ".load_count"}, WIDTH'(load_count), WIDTH'(cnt));
      chk({tag, ".seed_valid"}, WIDTH'(seed_valid), WIDTH'(v));
      chk({tag, ".busy"},       WIDTH'(busy),       WIDTH'(b));
      chk({tag, ".overflow"},   WIDTH'(overflow),   WIDTH'(o));
      chk({tag, ".seed_out"},   seed_out,           s);
   endtask

   // Pin high for 3 samples (capture at the third edge), then low for 2.
   task automatic do_strobe(input logic [7:0] d);
      @(negedge clk);
      byte_in     = d;
      byte_strobe = 1'b1;
      repeat (3) @(negedge clk);
      byte_strobe = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_start();
      @(negedge clk);
      frame_start = 1'b1;
      repeat (3) @(negedge clk);
      frame_start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_hs();
      @(negedge clk);
      seed_ready = 1'b1;
      @(negedge clk);
      seed_ready = 1'b0;
      @(negedge clk);
   endtask

   function automatic void add(input int op, input logic [7:0] d,
                               input logic [CW-1:0] c, input logic v,
                               input logic b, input logic o,
                               input logic [WIDTH-1:0] s);
      vec_t e;
      e.op = op; e.data = d; e.cnt = c; e.valid = v;
      e.busy = b; e.ovf = o; e.seed = s;
      tbl.push_back(e);
   endfunction

   initial begin
      logic [WIDTH-1:0] s;
      n_cmp = 0;
      n_bad = 0;

      // ---------------- expected-value table ----------------
      s = '0;
      add(OP_START, 8'h00, 6'd0, 1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 32; i++) begin
         s = {s[WIDTH-9:0], 8'(i)};
         add(OP_STROBE, 8'(i), 6'(i + 1), (i == 31), (i != 31), 1'b0, s);
      end
      // Strobe while holding: dropped, overflow set.
      add(OP_STROBE, 8'hAA, 6'd32, 1'b1, 1'b0, 1'b1, s);
      // Handshake: back to IDLE, overflow sticky, seed retained.
      add(OP_HS, 8'h00, 6'd0, 1'b0, 1'b0, 1'b1, s);
      // Start clears overflow.
      add(OP_START, 8'h00, 6'd0, 1'b0, 1'b1, 1'b0, '0);
      s = '0;
      for (int i = 0; i < 10; i++) begin
         s = {s[WIDTH-9:0], 8'(8'h11 + i)};
         add(OP_STROBE, 8'(8'h11 + i), 6'(i + 1), 1'b0, 1'b1, 1'b0, s);
      end
      // Abort mid-frame.
      add(OP_START, 8'h00, 6'd0, 1'b0, 1'b1, 1'b0, '0);

      // ---------------- reset with strobe pin high ----------------
      rst_n       = 1'b0;
      ena         = 1'b1;
      byte_in     = 8'h5A;
      byte_strobe = 1'b1;
      frame_start = 1'b0;
      seed_ready  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_all("reset", 6'd0, 1'b0, 1'b0, 1'b0, '0);
      repeat (5) @(negedge clk);
      chk_all("reset_nocap", 6'd0, 1'b0, 1'b0, 1'b0, '0);
      byte_strobe = 1'b0;
      repeat (2) @(negedge clk);
      do_strobe(8'h66);
      chk("idle_strobe.load_count", WIDTH'(load_count), WIDTH'(6'd0));
      chk("idle_strobe.seed_out", seed_out, '0);

      // ---------------- table ----------------
      for (int k = 0; k < tbl.size(); k++) begin
         case (tbl[k].op)
            OP_START:  do_start();
            OP_STROBE: do_strobe(tbl[k].data);
            default:   do_hs();
         endcase
         chk_all($sformatf("vec%0d", k), tbl[k].cnt, tbl[k].valid,
                 tbl[k].busy, tbl[k].ovf, tbl[k].seed);
      end

      // ---------------- 0xFF frame, exact valid latency ----------------
      for (int i = 0; i < 31; i++) do_strobe(8'hFF);
      chk("ff31.load_count", WIDTH'(load_count), WIDTH'(6'd31));
      @(negedge clk);
      byte_in     = 8'hFF;
      byte_strobe = 1'b1;
      @(posedge clk);            // edge N: first sample
      @(posedge clk);            // edge N+1
      #1;
      chk("lat_n1.seed_valid", WIDTH'(seed_valid), WIDTH'(1'b0));
      chk("lat_n1.busy", WIDTH'(busy), WIDTH'(1'b1));
      @(posedge clk);            // edge N+2: capture
      #1;
      chk("lat_n2.seed_valid", WIDTH'(seed_valid), WIDTH'(1'b1));
      chk("lat_n2.busy", WIDTH'(busy), WIDTH'(1'b0));
      chk("lat_n2.load_count", WIDTH'(load_count), WIDTH'(6'd32));
      chk("lat_n2.seed_out", seed_out, '1);
      @(negedge clk);
      byte_strobe = 1'b0;
      repeat (2) @(negedge clk);

      // ---------------- ena low in HOLD blocks the handshake ----------------
      ena        = 1'b0;
      seed_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("ena_hold.seed_valid", WIDTH'(seed_valid), WIDTH'(1'b1));
      chk("ena_hold.load_count", WIDTH'(load_count), WIDTH'(6'd32));
      ena = 1'b1;
      @(negedge clk);
      chk("ena_hs.seed_valid", WIDTH'(seed_valid), WIDTH'(1'b0));
      chk("ena_hs.load_count", WIDTH'(load_count), WIDTH'(6'd0));
      seed_ready = 1'b0;
      @(negedge clk);

      // ---------------- simultaneous start + strobe ----------------
      do_start();
      for (int i = 0; i < 5; i++) do_strobe(8'(8'h21 + i));
      chk("pre_sim.load_count", WIDTH'(load_count), WIDTH'(6'd5));
      @(negedge clk);
      byte_in     = 8'h77;
      byte_strobe = 1'b1;
      frame_start = 1'b1;
      repeat (3) @(negedge clk);
      chk_all("sim", 6'd0, 1'b0, 1'b1, 1'b0, '0);
      byte_strobe = 1'b0;
      frame_start = 1'b0;
      repeat (2) @(negedge clk);
      do_strobe(8'h33);
      chk_all("post_sim", 6'd1, 1'b0, 1'b1, 1'b0, WIDTH'(8'h33));

      // ---------------- ena low in COLLECT ----------------
      ena = 1'b0;
      for (int i = 0; i < 3; i++) do_strobe(8'h44);
      @(negedge clk);
      byte_in     = 8'h55;
      byte_strobe = 1'b1;
      repeat (5) @(negedge clk);
      ena = 1'b1;
      repeat (5) @(negedge clk);
      chk_all("ena_rise", 6'd1, 1'b0, 1'b1, 1'b0, WIDTH'(8'h33));
      byte_strobe = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
